// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP32 adder between two
// requesters; a {valid, id} tag pipeline routes each adder result back to its owner.
module fpu_add_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_data,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_valid,
    input  logic [31:0] add_result,
    input  logic        add_valid_out,
    output logic [3:0]  in_flight,
    output logic        err
);

    logic               r_last_grant;
    logic [LATENCY-1:0] r_tag_valid;
    logic [LATENCY-1:0] r_tag_id;
    logic [3:0]         r_in_flight;
    logic               r_err;

    logic w_grant0;
    logic w_grant1;
    logic w_issue;
    logic w_tag_last_valid;
    logic w_tag_last_id;

    // Contention goes to the requester that did not win last; reset and pause block all grants.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && !pause) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_issue          = w_grant0 | w_grant1;
    assign w_tag_last_valid = r_tag_valid[LATENCY-1];
    assign w_tag_last_id    = r_tag_id[LATENCY-1];

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign add_valid  = w_issue;
    assign add_a      = w_grant0 ? req0_a : (w_grant1 ? req1_a : 32'd0);
    assign add_b      = w_grant0 ? req0_b : (w_grant1 ? req1_b : 32'd0);

    // A result is routed only when the adder and the tag pipeline agree it exists.
    assign resp0_valid = !rst && add_valid_out && w_tag_last_valid && !w_tag_last_id;
    assign resp1_valid = !rst && add_valid_out && w_tag_last_valid &&  w_tag_last_id;
    assign resp_data   = rst ? 32'd0 : add_result;

    assign in_flight = r_in_flight;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_tag_valid  <= '0;
            r_in_flight  <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_issue) begin
                r_last_grant <= w_grant1;
            end
            r_tag_valid[0] <= w_issue;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
            end
            // Counting tag retirement keeps in_flight equal to the live tags even if the adder misbehaves.
            case ({w_issue, w_tag_last_valid})
                2'b10:   r_in_flight <= r_in_flight + 4'd1;
                2'b01:   r_in_flight <= r_in_flight - 4'd1;
                default: r_in_flight <= r_in_flight;
            endcase
            if (add_valid_out != w_tag_last_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: tag ids carry no reset; an id is only ever read alongside its valid bit, which is reset.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_grant1;
        for (int i = 1; i < LATENCY; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: two builds (LATENCY 4 and 1) share one stimulus stream,
// each with its own behavioural FP32 adder, checked against a scoreboard of expected responses.
module tb_fpu_add_arbiter;

    localparam int L0 = 4;
    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pause, v0, v1, inj;
    logic [31:0] a0, b0, a1, b1;

    logic [1:0]  r0, r1, avld, rv0, rv1, avo, errs;
    logic [31:0] adda [2];
    logic [31:0] addb [2];
    logic [31:0] rdata [2];
    logic [31:0] ares [2];
    logic [3:0]  infl [2];

    fpu_add_arbiter #(.LATENCY(L0)) u_dut0 (
        .clk(clk), .rst(rst), .pause(pause),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1[0]),
        .resp0_valid(rv0[0]), .resp1_valid(rv1[0]), .resp_data(rdata[0]),
        .add_a(adda[0]), .add_b(addb[0]), .add_valid(avld[0]),
        .add_result(ares[0]), .add_valid_out(avo[0]),
        .in_flight(infl[0]), .err(errs[0])
    );

    fpu_add_arbiter #(.LATENCY(L1)) u_dut1 (
        .clk(clk), .rst(rst), .pause(pause),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1[1]),
        .resp0_valid(rv0[1]), .resp1_valid(rv1[1]), .resp_data(rdata[1]),
        .add_a(adda[1]), .add_b(addb[1]), .add_valid(avld[1]),
        .add_result(ares[1]), .add_valid_out(avo[1]),
        .in_flight(infl[1]), .err(errs[1])
    );

    // FP32 <-> real conversion for normal numbers and zero, enough for a reference adder.
    function automatic real fp2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        return r2fp(fp2r(x) + fp2r(y));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    // Behavioural pipelined adders, reset together with the arbiter by the integrator.
    logic        pv [2][8];
    logic [31:0] pd [2][8];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) pv[d][i] <= 1'b0;
            end else begin
                for (int i = 7; i > 0; i--) pv[d][i] <= pv[d][i-1];
                pv[d][0] <= avld[d];
            end
            for (int i = 7; i > 0; i--) pd[d][i] <= pd[d][i-1];
            pd[d][0] <= fp_add(adda[d], addb[d]);
        end
    end
    assign avo[0]  = pv[0][L0-1] | inj;
    assign ares[0] = pd[0][L0-1];
    assign avo[1]  = pv[1][L1-1] | inj;
    assign ares[1] = pd[1][L1-1];

    // Scoreboard: one entry per accepted operation per build, retired on its due cycle.
    typedef struct {
        int          dut;
        int          id;
        logic [31:0] data;
        int          due;
    } op_t;

    op_t  q [$];
    int   cyc;
    logic m_last;
    logic m_err [2];
    logic m_g0, m_g1;
    int   n_vec;
    int   n_bad;

    logic        s_rst, s_pause, s_v0, s_v1, s_inj;
    logic [31:0] s_a0, s_b0, s_a1, s_b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic cycle();
        logic nerr [2];
        @(posedge clk);
        cyc++;
        #1;
        rst = s_rst; pause = s_pause; inj = s_inj;
        v0 = s_v0; a0 = s_a0; b0 = s_b0;
        v1 = s_v1; a1 = s_a1; b1 = s_b1;
        #4;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (s_rst) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d rst ready0", d), r0[d], 0);
                check($sformatf("d%0d rst ready1", d), r1[d], 0);
                check($sformatf("d%0d rst add_valid", d), avld[d], 0);
                check($sformatf("d%0d rst resp0", d), rv0[d], 0);
                check($sformatf("d%0d rst resp1", d), rv1[d], 0);
                check($sformatf("d%0d rst add_a", d), adda[d], 0);
                check($sformatf("d%0d rst add_b", d), addb[d], 0);
                check($sformatf("d%0d rst resp_data", d), rdata[d], 0);
                m_err[d] = 1'b0;
            end
            q.delete();
            m_last = 1'b1;
        end else begin
            m_g0 = !s_pause && s_v0 && (!s_v1 || m_last);
            m_g1 = !s_pause && s_v1 && (!s_v0 || !m_last);
            for (int d = 0; d < 2; d++) begin
                int cnt;
                int hit;
                cnt = 0;
                hit = -1;
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k].dut == d) begin
                        cnt++;
                        if (q[k].due == cyc) hit = k;
                    end
                end
                check($sformatf("d%0d ready0", d), r0[d], m_g0);
                check($sformatf("d%0d ready1", d), r1[d], m_g1);
                check($sformatf("d%0d add_valid", d), avld[d], m_g0 | m_g1);
                check($sformatf("d%0d add_a", d), adda[d], m_g0 ? s_a0 : (m_g1 ? s_a1 : 32'd0));
                check($sformatf("d%0d add_b", d), addb[d], m_g0 ? s_b0 : (m_g1 ? s_b1 : 32'd0));
                check($sformatf("d%0d in_flight", d), infl[d], cnt);
                check($sformatf("d%0d err", d), errs[d], m_err[d]);
                check($sformatf("d%0d resp0", d), rv0[d], (hit >= 0) && (q[hit].id == 0));
                check($sformatf("d%0d resp1", d), rv1[d], (hit >= 0) && (q[hit].id == 1));
                if (hit >= 0) check($sformatf("d%0d resp_data", d), rdata[d], q[hit].data);
                nerr[d] = m_err[d] | (s_inj && hit < 0);
            end
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].due == cyc) q.delete(k);
            end
            if (m_g0 || m_g1) begin
                for (int d = 0; d < 2; d++) begin
                    op_t e;
                    e.dut  = d;
                    e.id   = m_g1 ? 1 : 0;
                    e.data = m_g1 ? fp_add(s_a1, s_b1) : fp_add(s_a0, s_b0);
                    e.due  = cyc + lat(d);
                    q.push_back(e);
                end
                m_last = m_g1;
            end
            for (int d = 0; d < 2; d++) m_err[d] = nerr[d];
        end
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        repeat (2) cycle();
        s_rst = 1'b0;
    endtask

    initial begin
        int n0, n1, peak;
        n_vec = 0; n_bad = 0; cyc = 0;
        m_last = 1'b1;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        s_rst = 1'b1; s_pause = 1'b0; s_inj = 1'b0;
        s_v0 = 1'b1; s_a0 = 32'h3F800000; s_b0 = 32'h40000000;
        s_v1 = 1'b1; s_a1 = 32'h40400000; s_b1 = 32'h40400000;
        rst = 1'b1; pause = 1'b0; inj = 1'b0;
        v0 = 1'b1; a0 = s_a0; b0 = s_b0;
        v1 = 1'b1; a1 = s_a1; b1 = s_b1;

        // Reset with both requesters valid: nothing may be granted.
        do_reset();
        s_v0 = 1'b0; s_v1 = 1'b0;
        cycle();
        check("t0 in_flight after reset", infl[0], 0);
        check("t0 err after reset", errs[0], 0);

        // Single request 1.0 + 2.0.
        s_v0 = 1'b1; s_a0 = 32'h3F800000; s_b0 = 32'h40000000;
        cycle();
        check("t1 ready0", r0[0], 1);
        check("t1 add_valid", avld[0], 1);
        s_v0 = 1'b0;
        repeat (3) cycle();
        check("t1 resp0 not early", rv0[0], 0);
        cycle();
        check("t1 resp0", rv0[0], 1);
        check("t1 resp_data", rdata[0], 32'h40400000);
        check("t1 resp1", rv1[0], 0);

        // Both valid for 6 cycles: grants alternate starting with req0.
        do_reset();
        s_a0 = 32'h3FC00000; s_b0 = 32'h40200000;
        s_a1 = 32'h40400000; s_b1 = 32'h40400000;
        s_v0 = 1'b1; s_v1 = 1'b1;
        n0 = 0; n1 = 0; peak = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) begin s_v0 = 1'b0; s_v1 = 1'b0; end
            cycle();
            if (i < 6) check($sformatf("t2 grant0 #%0d", i), r0[0], (i % 2 == 0));
            if (i >= 1 && i <= 6) begin
                check($sformatf("t2 lat1 resp0 #%0d", i), rv0[1], (i % 2 == 1));
                check($sformatf("t2 lat1 resp1 #%0d", i), rv1[1], (i % 2 == 0));
            end
            if (int'(infl[0]) > peak) peak = int'(infl[0]);
            if (rv0[0]) begin n0++; check("t2 resp0 data", rdata[0], 32'h40800000); end
            if (rv1[0]) begin n1++; check("t2 resp1 data", rdata[0], 32'h40C00000); end
        end
        check("t2 resp0 count", n0, 3);
        check("t2 resp1 count", n1, 3);
        check("t2 in_flight peak", peak, L0);

        // req1 stream of 10 cycles with pause from cycle 5.
        s_v1 = 1'b1; s_a1 = rnd_fp(); s_b1 = rnd_fp();
        n1 = 0;
        for (int i = 0; i < 16; i++) begin
            s_pause = (i >= 5);
            if (i == 10) s_v1 = 1'b0;
            cycle();
            if (i < 10) check($sformatf("t3 ready1 #%0d", i), r1[0], (i < 5));
            if (rv1[0]) n1++;
            if (i == 8) check("t3 in_flight before drain", infl[0], 1);
            if (i == 9) check("t3 in_flight drained", infl[0], 0);
        end
        s_pause = 1'b0;
        check("t3 response count", n1, 5);

        // Spurious adder valid: sticky err, nothing routed.
        repeat (2) cycle();
        s_inj = 1'b1;
        cycle();
        check("t4 resp0 on spurious", rv0[0], 0);
        check("t4 resp1 on spurious", rv1[0], 0);
        s_inj = 1'b0;
        repeat (3) cycle();
        check("t4 err sticky", errs[0], 1);
        check("t4 err sticky lat1", errs[1], 1);
        do_reset();
        cycle();
        check("t4 err cleared", errs[0], 0);

        // Reset with operations in flight.
        s_v0 = 1'b1; s_a0 = rnd_fp(); s_b0 = rnd_fp();
        repeat (3) cycle();
        s_v0 = 1'b0;
        repeat (2) cycle();
        do_reset();
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (rv0[0] || rv1[0] || rv0[1] || rv1[1]) n0++;
        end
        check("t5 stale responses", n0, 0);
        check("t5 in_flight", infl[0], 0);
        s_v0 = 1'b1; s_v1 = 1'b1;
        cycle();
        check("t5 first grant req0", r0[0], 1);
        check("t5 first grant not req1", r1[0], 0);
        s_v0 = 1'b0; s_v1 = 1'b0;
        repeat (6) cycle();

        // Random traffic: requesters hold operands until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!s_v0 && $urandom_range(0, 2) != 0) begin
                s_v0 = 1'b1; s_a0 = rnd_fp(); s_b0 = rnd_fp();
            end
            if (!s_v1 && $urandom_range(0, 2) != 0) begin
                s_v1 = 1'b1; s_a1 = rnd_fp(); s_b1 = rnd_fp();
            end
            s_pause = ($urandom_range(0, 9) == 0);
            cycle();
            if (m_g0) s_v0 = 1'b0;
            if (m_g1) s_v1 = 1'b0;
        end
        s_v0 = 1'b0; s_v1 = 1'b0; s_pause = 1'b0;
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one pipelined FP32 adder (fixed latency, valid-in/valid-out, no backpressure) between two requesters.
- Arbitration is round-robin.
- A tag pipeline tracks which requester owns each in-flight operation and routes each result back to it.
- Sits between the two requester ports and the shared adder instance. Also reports occupancy and flags a sticky protocol error.

Parameters:
- LATENCY, 4: cycles from adder valid_in to adder valid_out. Range 1..8.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous reset, active-high.
- pause, input, 1: when high, no new grants; in-flight operations still complete.
- req0_valid, input, 1: requester 0 has an operation.
- req0_a, input, 32: requester 0 operand A (FP32).
- req0_b, input, 32: requester 0 operand B (FP32).
- req0_ready, output, 1: requester 0 operation accepted this cycle.
- req1_valid, input, 1: requester 1 has an operation.
- req1_a, input, 32: requester 1 operand A.
- req1_b, input, 32: requester 1 operand B.
- req1_ready, output, 1: requester 1 operation accepted this cycle.
- resp0_valid, output, 1: result for requester 0 present.
- resp1_valid, output, 1: result for requester 1 present.
- resp_data, output, 32: result data, shared by both response ports.
- add_a, output, 32: operand A to adder.
- add_b, output, 32: operand B to adder.
- add_valid, output, 1: issue strobe to adder.
- add_result, input, 32: adder result.
- add_valid_out, input, 1: adder result valid.
- in_flight, output, 4: count of issued operations not yet returned.
- err, output, 1: sticky protocol error.

Behaviour:
- Reset (rst high at a clk edge) clears:
  - tag pipeline, in_flight, err;
  - last_grant is set to 1, so requester 0 wins the first contention.
- Outputs while rst is high:
  - req0_ready, req1_ready, add_valid, resp0_valid, resp1_valid are all 0;
  - add_a, add_b, resp_data are 0.
- Grant is combinational from current inputs and registered state:
  - no grant if pause or rst is high;
  - if exactly one reqN_valid is high, that requester is granted;
  - if both are high, the requester not equal to last_grant is granted;
  - last_grant updates to the granted id on each grant.
- Handshake:
  - reqN_ready = grant to N; transfer occurs when reqN_valid && reqN_ready;
  - requesters hold valid and operands until ready;
  - at most one issue per cycle, so the adder is never overdriven.
- Issue path:
  - add_valid = any grant;
  - add_a/add_b = granted requester's operands, muxed combinationally;
  - add_a/add_b = 0 when no grant.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, id}; stage 0 loads {add_valid, granted id} each clk.
  - The last stage aligns with add_valid_out in the same cycle as the adder result.
- Response routing:
  - resp_data = add_result, combinational pass-through;
  - respN_valid = add_valid_out && tag_last.valid && tag_last.id == N;
  - there is no response backpressure: requesters must accept on the valid cycle.
- Issue-to-response latency: exactly LATENCY cycles. An operation accepted at edge k produces respN_valid during the cycle after edge k+LATENCY-1.
- in_flight:
  - +1 on issue, −1 on tagged response; both in the same cycle leaves it unchanged;
  - never exceeds LATENCY.
- err:
  - set when add_valid_out != tag_last.valid in any cycle after reset;
  - cleared only by rst;
  - a mismatched result is never routed to either response port.
- Pause:
  - takes effect the same cycle (ready drops combinationally);
  - the pipeline drains; in_flight reaches 0 after LATENCY cycles.
- Reset mid-operation:
  - in-flight tags are discarded and no responses are produced for them;
  - the adder must be reset in the same cycle by the integrator.
- Back-to-back: a continuous request stream gives one issue per cycle with no bubbles.
- Both requesters continuously valid: grants alternate 0, 1, 0, 1, …

Test Plan:
- Reset, then req0 only with a=0x3F800000 (1.0), b=0x40000000 (2.0) -> req0_ready=1 that cycle; add_valid=1; resp0_valid=1 with resp_data=0x40400000 (3.0) exactly LATENCY cycles later; resp1_valid stays 0.
- Both valid for 6 cycles; req0 (0x3FC00000, 0x40200000), req1 (0x40400000, 0x40400000) -> grants 0,1,0,1,0,1; responses alternate resp0_valid 0x40800000 (4.0) and resp1_valid 0x40C00000 (6.0); in_flight peaks at LATENCY.
- Streaming req1 only for 10 cycles with pause asserted on cycle 5 -> ready low from cycle 5; exactly 5 responses; in_flight returns to 0 LATENCY cycles after pause.
- Bench injects add_valid_out=1 with no issued operation -> err=1 and stays 1; resp0_valid=resp1_valid=0; err cleared only after rst.
- rst asserted 2 cycles after 3 issues -> ready/valid outputs 0 during reset; in_flight=0 after; no stale responses; first post-reset contention grants req0.
- LATENCY=1 build, alternating requests every cycle -> each response arrives the cycle after its issue on the correct port.
